// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants for the instruction-fetch stage.
//  Revision    : 1.0
// ============================================================================
package fetch_pkg;

    localparam int          FETCH_ADDR_W   = 32;
    localparam int          FETCH_INSTR_W  = 32;
    localparam int          FETCH_CNT_W    = 16;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP        = 4;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    // A redirect target is misaligned when either of its two low byte bits is set.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : Program counter with reset / redirect / increment / hold mux.
//  Revision    : 1.0
// ============================================================================
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_redir,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_seq
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_seq;

    // Natural ADDR_W-bit overflow gives the required wrap from the top word to 0.
    assign w_pc_seq = r_pc + ADDR_W'(PC_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redir) begin
            r_pc <= i_target;
        end else if (i_advance) begin
            r_pc <= w_pc_seq;
        end
    end

    assign o_pc     = r_pc;
    assign o_pc_seq = w_pc_seq;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_stage
//  Description : PC, instruction-memory addressing and IF/ID register with
//                valid/ready handshake, redirect flush and delivery counter.
//  Revision    : 1.0
// ============================================================================
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter int                CNT_W    = FETCH_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc4,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_target,
    output logic               misalign,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_pc_seq;
    logic [ADDR_W-1:0]  w_target_aligned;
    logic               w_advance;
    logic               w_handoff;

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_pc4;
    logic               r_misalign;
    logic [CNT_W-1:0]   r_count;

    assign w_advance        = !r_valid || out_ready;
    // A redirect in the same cycle squashes the handoff of the wrong-path instruction.
    assign w_handoff        = r_valid && out_ready && !redir_valid;
    assign w_target_aligned = {redir_target[ADDR_W-1:2], 2'b00};

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (reset),
        .i_redir   (redir_valid),
        .i_target  (w_target_aligned),
        .i_advance (w_advance),
        .o_pc      (w_pc),
        .o_pc_seq  (w_pc_seq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= INSTR_W'(NOP_INSTR);
            r_pc       <= '0;
            r_pc4      <= '0;
            r_misalign <= 1'b0;
        end else if (redir_valid) begin
            r_valid    <= 1'b0;
            r_misalign <= is_misaligned(redir_target[1:0]);
        end else begin
            r_misalign <= 1'b0;
            if (w_advance) begin
                r_valid <= 1'b1;
                r_instr <= imem_data;
                r_pc    <= w_pc;
                r_pc4   <= w_pc_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_handoff && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign imem_addr   = w_pc;
    assign out_valid   = r_valid;
    assign out_instr   = r_instr;
    assign out_pc      = r_pc;
    assign out_pc4     = r_pc4;
    assign misalign    = r_misalign;
    assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_stage
//  Description : Directed self-checking bench for instr_fetch_stage.
//  Revision    : 1.0
// ============================================================================
module tb_instr_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        misalign;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    instr_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc4      (out_pc4),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .misalign     (misalign),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: mem[A] = A ^ 32'hA5A5_0000 (e.g. I0=A5A50000, I3=A5A5000C).
    assign imem_data = imem_addr ^ 32'hA5A5_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        redir_valid  = 1'b0;
        redir_target = 32'h0;
        out_ready    = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, misalign, imem_addr, out_instr, out_pc, out_pc4, fetch_count} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state: valid=%b mis=%b addr=%h instr=%h pc=%h pc4=%h cnt=%0d, need all zero",
                     out_valid, misalign, imem_addr, out_instr, out_pc, out_pc4, fetch_count);
        end
    endtask

    // Streams I0..I2, leaving IF/ID holding pc 8 with imem_addr at 12.
    task automatic test_stream();
        logic [31:0] exp_instr [3] = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008};
        logic [31:0] exp_pc    [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_pc4   [3] = '{32'h4, 32'h8, 32'hC};
        logic [15:0] exp_cnt   [3] = '{16'd0, 16'd1, 16'd2};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, out_instr, out_pc, out_pc4, fetch_count} !==
                {1'b1, exp_instr[i], exp_pc[i], exp_pc4[i], exp_cnt[i]}) begin
                errors++;
                $display("FAIL stream[%0d]: got v=%b instr=%h pc=%h pc4=%h cnt=%0d, need v=1 instr=%h pc=%h pc4=%h cnt=%0d",
                         i, out_valid, out_instr, out_pc, out_pc4, fetch_count,
                         exp_instr[i], exp_pc[i], exp_pc4[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, out_instr, out_pc, imem_addr, fetch_count} !==
                {1'b1, 32'hA5A5_0008, 32'h8, 32'hC, 16'd2}) begin
                errors++;
                $display("FAIL stall[%0d]: got v=%b instr=%h pc=%h addr=%h cnt=%0d, need v=1 instr=a5a50008 pc=8 addr=c cnt=2",
                         i, out_valid, out_instr, out_pc, imem_addr, fetch_count);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_instr, out_pc, out_pc4, fetch_count} !==
            {1'b1, 32'hA5A5_000C, 32'hC, 32'h10, 16'd3}) begin
            errors++;
            $display("FAIL stall_release: got v=%b instr=%h pc=%h pc4=%h cnt=%0d, need v=1 instr=a5a5000c pc=c pc4=10 cnt=3",
                     out_valid, out_instr, out_pc, out_pc4, fetch_count);
        end
        step();
        checks++;
        if ({out_pc, fetch_count} !== {32'h10, 16'd4}) begin
            errors++;
            $display("FAIL count_after_i3: got pc=%h cnt=%0d, need pc=10 cnt=4", out_pc, fetch_count);
        end
    endtask

    task automatic test_redirect();
        redir_valid  = 1'b1;
        redir_target = 32'h40;
        step();
        redir_valid = 1'b0;
        checks++;
        if ({out_valid, imem_addr, fetch_count, misalign} !== {1'b0, 32'h40, 16'd4, 1'b0}) begin
            errors++;
            $display("FAIL redirect_flush: got v=%b addr=%h cnt=%0d mis=%b, need v=0 addr=40 cnt=4 mis=0",
                     out_valid, imem_addr, fetch_count, misalign);
        end
        step();
        checks++;
        if ({out_valid, out_instr, out_pc, out_pc4, fetch_count} !==
            {1'b1, 32'hA5A5_0040, 32'h40, 32'h44, 16'd4}) begin
            errors++;
            $display("FAIL redirect_target: got v=%b instr=%h pc=%h pc4=%h cnt=%0d, need v=1 instr=a5a50040 pc=40 pc4=44 cnt=4",
                     out_valid, out_instr, out_pc, out_pc4, fetch_count);
        end
    endtask

    task automatic test_misalign();
        redir_valid  = 1'b1;
        redir_target = 32'h42;
        step();
        redir_valid = 1'b0;
        checks++;
        if ({misalign, out_valid, imem_addr} !== {1'b1, 1'b0, 32'h40}) begin
            errors++;
            $display("FAIL misalign_pulse: got mis=%b v=%b addr=%h, need mis=1 v=0 addr=40",
                     misalign, out_valid, imem_addr);
        end
        step();
        checks++;
        if ({misalign, out_valid, out_pc, fetch_count} !== {1'b0, 1'b1, 32'h40, 16'd4}) begin
            errors++;
            $display("FAIL misalign_clear: got mis=%b v=%b pc=%h cnt=%0d, need mis=0 v=1 pc=40 cnt=4",
                     misalign, out_valid, out_pc, fetch_count);
        end
    endtask

    task automatic test_pc_wrap();
        redir_valid  = 1'b1;
        redir_target = 32'hFFFF_FFFC;
        step();
        redir_valid = 1'b0;
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_redirect: got v=%b addr=%h, need v=0 addr=fffffffc", out_valid, imem_addr);
        end
        step();
        checks++;
        if ({out_valid, out_instr, out_pc, out_pc4, imem_addr} !==
            {1'b1, 32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL wrap_top: got v=%b instr=%h pc=%h pc4=%h addr=%h, need v=1 instr=5a5afffc pc=fffffffc pc4=0 addr=0",
                     out_valid, out_instr, out_pc, out_pc4, imem_addr);
        end
        step();
        checks++;
        if ({out_instr, out_pc, out_pc4, fetch_count} !== {32'hA5A5_0000, 32'h0, 32'h4, 16'd5}) begin
            errors++;
            $display("FAIL wrap_zero: got instr=%h pc=%h pc4=%h cnt=%0d, need instr=a5a50000 pc=0 pc4=4 cnt=5",
                     out_instr, out_pc, out_pc4, fetch_count);
        end
    endtask

    task automatic test_reset_priority();
        reset        = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'h83;
        step();
        checks++;
        if ({out_valid, imem_addr, fetch_count, misalign, out_pc} !==
            {1'b0, 32'h0, 16'd0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_priority: got v=%b addr=%h cnt=%0d mis=%b pc=%h, need v=0 addr=0 cnt=0 mis=0 pc=0",
                     out_valid, imem_addr, fetch_count, misalign, out_pc);
        end
        reset       = 1'b0;
        redir_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, out_instr, out_pc, fetch_count} !== {1'b1, 32'hA5A5_0000, 32'h0, 16'd0}) begin
            errors++;
            $display("FAIL reset_restart: got v=%b instr=%h pc=%h cnt=%0d, need v=1 instr=a5a50000 pc=0 cnt=0",
                     out_valid, out_instr, out_pc, fetch_count);
        end
    endtask

    // After N edges of free streaming from reset the count is min(N-1, 65535).
    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 65535; i++) step();
        checks++;
        if (fetch_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL count_near_max: got %h, need fffe", fetch_count);
        end
        step();
        checks++;
        if (fetch_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_at_max: got %h, need ffff", fetch_count);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (fetch_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_saturated: got %h, need ffff", fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_pc_wrap();
        test_reset_priority();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
